// File: rtl/dm_abstract_seq.sv
// Abstract-command sequencer: turns one Access Register command into debug-memory instruction words.
// Optional macro DM_CHERI_CAP_EN: dscratch1 save/restore via CSpecialRW and 64-bit GPR clc/csc.
module dm_abstract_seq #(
  parameter int unsigned AbsDepth = 10,
  parameter logic [11:0] DataAddr = 12'h380,
  parameter int unsigned IdxW     = $clog2(AbsDepth)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [31:0]     cmd_i,
  output logic            abs_we_o,
  input  logic            abs_gnt_i,
  output logic [IdxW-1:0] abs_idx_o,
  output logic [31:0]     abs_wdata_o,
  output logic            done_o,
  output logic [2:0]      cmderr_o,
  output logic            regno_upd_valid_o,
  output logic [15:0]     regno_upd_o
);

  // Handshakes: a command transfers on a cycle with cmd_valid_i && cmd_ready_o; a buffer
  // word transfers on a cycle with abs_we_o && abs_gnt_i, and abs_we_o/idx/wdata hold until then.

  typedef enum logic [1:0] {IDLE, EMIT, FILL, DONE} state_e;

  localparam logic [31:0]     InstrNop     = 32'h0000_0013;
  localparam logic [31:0]     InstrEbreak  = 32'h0010_0073;
  localparam logic [31:0]     InstrIllegal = 32'h0000_0000;
  localparam logic [4:0]      RegA0        = 5'd10;
  localparam logic [IdxW-1:0] LastIdx      = IdxW'(AbsDepth - 1);

  function automatic logic [31:0] enc_load(input logic [2:0] f3, input logic [4:0] rd);
    return {DataAddr, 5'd0, f3, rd, 7'h03};
  endfunction

  function automatic logic [31:0] enc_store(input logic [2:0] f3, input logic [4:0] rs2);
    return {DataAddr[11:5], rs2, 5'd0, f3, DataAddr[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_csrw(input logic [11:0] csr, input logic [4:0] rs1);
    return {csr, rs1, 3'b001, 5'd0, 7'h73};
  endfunction

  function automatic logic [31:0] enc_csrr(input logic [11:0] csr, input logic [4:0] rd);
    return {csr, 5'd0, 3'b010, rd, 7'h73};
  endfunction

`ifdef DM_CHERI_CAP_EN
  localparam logic [31:0] ScratchSave    = {7'h01, 5'h1A, RegA0, 3'b000, 5'd0, 7'h5B};
  localparam logic [31:0] ScratchRestore = {7'h01, 5'h1A, 5'd0, 3'b000, RegA0, 7'h5B};
`else
  localparam logic [31:0] ScratchSave    = {12'h7B3, RegA0, 3'b001, 5'd0, 7'h73};
  localparam logic [31:0] ScratchRestore = {12'h7B3, 5'd0, 3'b010, RegA0, 7'h73};
`endif

  function automatic logic decode_err(input logic [31:0] c);
    logic [2:0]  sz;
    logic [15:0] rn;
    sz = c[22:20];
    rn = c[15:0];
    if (c[31:24] != 8'd0) return 1'b1;
    if (!c[17]) return 1'b0;
    if (rn >= 16'h1020) return 1'b1;
`ifdef DM_CHERI_CAP_EN
    if (rn >= 16'h1000) return !(sz == 3'd2 || sz == 3'd3);
`else
    if (rn >= 16'h1000) return sz != 3'd2;
`endif
    return sz != 3'd2;
  endfunction

  state_e            state_q, state_d;
  logic [22:0]       cmd_q;
  logic              err_q;
  logic [IdxW-1:0]   idx_q;
  logic              unused_cmd_bit;

  assign unused_cmd_bit = cmd_i[23];

  logic [2:0]  aarsize;
  logic        postinc, postexec, transfer, write_op, is_gpr;
  logic [15:0] regno;
  logic [2:0]  seq_last;
  logic [IdxW-1:0] term_idx;
  logic [31:0] emit_word;

  assign aarsize  = cmd_q[22:20];
  assign postinc  = cmd_q[19];
  assign postexec = cmd_q[18];
  assign transfer = cmd_q[17];
  assign write_op = cmd_q[16];
  assign regno    = cmd_q[15:0];
  assign is_gpr   = regno >= 16'h1000;
  // Terminator slot: after 1 word for a GPR, 4 for a CSR, straight away with no transfer.
  assign seq_last = transfer ? (is_gpr ? 3'd1 : 3'd4) : 3'd0;
  assign term_idx = IdxW'(seq_last);

  always_comb begin
    emit_word = InstrIllegal;
    if (idx_q == term_idx) begin
      emit_word = postexec ? InstrNop : InstrEbreak;
    end else if (is_gpr) begin
      emit_word = write_op ? enc_load(aarsize, regno[4:0]) : enc_store(aarsize, regno[4:0]);
    end else begin
      case (idx_q[1:0])
        2'd0:    emit_word = ScratchSave;
        2'd1:    emit_word = write_op ? enc_load(3'd2, RegA0) : enc_csrr(regno[11:0], RegA0);
        2'd2:    emit_word = write_op ? enc_csrw(regno[11:0], RegA0) : enc_store(3'd2, RegA0);
        default: emit_word = ScratchRestore;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid_i) state_d = decode_err(cmd_i) ? DONE : EMIT;
      EMIT: if (abs_gnt_i && idx_q == term_idx) state_d = FILL;
      FILL: if (abs_gnt_i && idx_q == LastIdx) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cmd_q <= '0;
      err_q <= 1'b0;
      idx_q <= '0;
    end else if (state_q == IDLE) begin
      if (cmd_valid_i) begin
        cmd_q <= cmd_i[22:0];
        err_q <= decode_err(cmd_i);
        idx_q <= '0;
      end
    end else if ((state_q == EMIT || state_q == FILL) && abs_gnt_i && idx_q != LastIdx) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  always_comb begin
    cmd_ready_o       = 1'b0;
    abs_we_o          = 1'b0;
    abs_idx_o         = '0;
    abs_wdata_o       = '0;
    done_o            = 1'b0;
    cmderr_o          = 3'd0;
    regno_upd_valid_o = 1'b0;
    regno_upd_o       = 16'd0;
    case (state_q)
      IDLE: cmd_ready_o = 1'b1;
      EMIT: begin
        abs_we_o    = 1'b1;
        abs_idx_o   = idx_q;
        abs_wdata_o = emit_word;
      end
      FILL: begin
        abs_we_o    = 1'b1;
        abs_idx_o   = idx_q;
        abs_wdata_o = InstrIllegal;
      end
      default: begin
        done_o   = 1'b1;
        cmderr_o = err_q ? 3'd2 : 3'd0;
        if (postinc && !err_q) begin
          regno_upd_valid_o = 1'b1;
          regno_upd_o       = regno + 16'd1;
        end
      end
    endcase
  end

endmodule
